// File: rtl/blur_pkg.sv
// Types and constants shared by the blur scheduler, the blur datapath and the HSV conversion.
package blur_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int SEL_W        = 4;
  localparam int CNT_W        = 13;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/blur_sched_ptr.sv
// Line/frame-end detector: flags the last active pixel of a line and of a frame.
module blur_sched_ptr
  import blur_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             pix_valid,
  input  logic [CNT_W-1:0] x_count,
  input  logic [CNT_W-1:0] y_count,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  assign line_end  = pix_valid && (x_count == X_LAST);
  assign frame_end = line_end && (y_count == Y_LAST);

endmodule

// File: rtl/blur_sched.sv
// Frame-synchronous filter-select scheduler: applies requested filter codes only at frame
// boundaries and holds the downstream mux in bypass while the blur line buffers refill.
module blur_sched
  import blur_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int FLUSH_LINES = 2,
  parameter int MAX_SEL     = 9,
  parameter int DEFAULT_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [CNT_W-1:0] x_count,
  input  logic [CNT_W-1:0] y_count,
  input  logic             req_stb,
  input  logic [SEL_W-1:0] req_sel,
  output logic [SEL_W-1:0] filt_sel,
  output logic             bypass,
  output logic             busy,
  output logic             applied,
  output logic             req_err
);

  localparam logic [3:0]       FLUSH_LAST = (FLUSH_LINES == 0) ? 4'd0 : 4'(FLUSH_LINES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(MAX_SEL);
  localparam logic [SEL_W-1:0] SEL_RST    = SEL_W'(DEFAULT_SEL);

  state_t           state_reg;
  logic [SEL_W-1:0] pend_sel_reg;
  logic             pend_flag_reg;
  logic [3:0]       cnt_reg;

  logic             line_end;
  logic             frame_end;
  logic             legal;
  logic             accept_run;
  logic             apply_go;
  logic [SEL_W-1:0] eff_sel;

  blur_sched_ptr #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_ptr (
    .pix_valid (pix_valid),
    .x_count   (x_count),
    .y_count   (y_count),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // A differing request landing on the frame-end beat while idle applies straight away.
  always_comb begin
    legal      = req_stb && (req_sel <= SEL_MAX);
    eff_sel    = legal ? req_sel : pend_sel_reg;
    accept_run = (state_reg == RUN) && legal && (req_sel != filt_sel);
    apply_go   = frame_end && ((state_reg == PEND) || accept_run);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      pend_sel_reg  <= SEL_RST;
      pend_flag_reg <= 1'b0;
      cnt_reg       <= 4'd0;
      filt_sel      <= SEL_RST;
      bypass        <= 1'b0;
      busy          <= 1'b0;
      applied       <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      applied <= 1'b0;
      req_err <= req_stb && !legal;
      if (legal) pend_sel_reg <= req_sel;

      if (apply_go) begin
        pend_flag_reg <= 1'b0;
        if (eff_sel != filt_sel) begin
          filt_sel <= eff_sel;
          applied  <= 1'b1;
          if (FLUSH_LINES > 0) begin
            bypass    <= 1'b1;
            cnt_reg   <= 4'd0;
            state_reg <= FLUSH;
            busy      <= 1'b1;
          end else begin
            state_reg <= RUN;
            busy      <= 1'b0;
          end
        end else begin
          state_reg <= RUN;
          busy      <= 1'b0;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (accept_run) begin
              pend_flag_reg <= 1'b1;
              state_reg     <= PEND;
              busy          <= 1'b1;
            end
          end
          PEND: begin
            if (legal) pend_flag_reg <= 1'b1;
          end
          FLUSH: begin
            if (legal) pend_flag_reg <= 1'b1;
            // frame_end here only counts as a line end; filt_sel is frozen mid-flush.
            if (line_end) begin
              if (cnt_reg == FLUSH_LAST) begin
                bypass <= 1'b0;
                if (pend_flag_reg || legal) begin
                  state_reg <= PEND;
                  busy      <= 1'b1;
                end else begin
                  state_reg <= RUN;
                  busy      <= 1'b0;
                end
              end else begin
                cnt_reg <= cnt_reg + 4'd1;
              end
            end
          end
          default: begin
            state_reg <= RUN;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blur_sched.sv
// Directed testbench for blur_sched: drives individual pixel beats at chosen coordinates.
module tb_blur_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic [12:0] x_count = '0;
  logic [12:0] y_count = '0;
  logic        req_stb = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [3:0]  filt_sel;
  logic        bypass;
  logic        busy;
  logic        applied;
  logic        req_err;

  int compared = 0;
  int failed   = 0;

  blur_sched dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .x_count   (x_count),
    .y_count   (y_count),
    .req_stb   (req_stb),
    .req_sel   (req_sel),
    .filt_sel  (filt_sel),
    .bypass    (bypass),
    .busy      (busy),
    .applied   (applied),
    .req_err   (req_err)
  );

  always #5 clk = ~clk;

  // One clock with the given beat/request; outputs are sampled 1 ns after the edge.
  task automatic step(input logic pv, input logic [12:0] x, input logic [12:0] y,
                      input logic stb, input logic [3:0] sel);
    pix_valid = pv; x_count = x; y_count = y; req_stb = stb; req_sel = sel;
    @(posedge clk); #1;
    pix_valid = 1'b0; req_stb = 1'b0;
    $display("step pv=%0b x=%0d y=%0d stb=%0b sel=%0d -> filt_sel=%0d bypass=%0b busy=%0b applied=%0b req_err=%0b",
             pv, x, y, stb, sel, filt_sel, bypass, busy, applied, req_err);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(1, 639, 479, 1, 4'd3);
    step(1, 10, 5, 1, 4'd6);
    compared++; if (filt_sel !== 4'd0) begin failed++; $display("FAIL reset_filt_sel got %0d want 0", filt_sel); end
    compared++; if (bypass !== 1'b0) begin failed++; $display("FAIL reset_bypass got %0b want 0", bypass); end
    compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(negedge clk); rst = 1'b1;
    step(0, 0, 0, 0, 4'd0);
    compared++; if (filt_sel !== 4'd0 || bypass !== 1'b0 || busy !== 1'b0)
      begin failed++; $display("FAIL reset_release got sel=%0d byp=%0b busy=%0b want 0/0/0", filt_sel, bypass, busy); end
  endtask

  task automatic test_apply;
    step(1, 10, 5, 1, 4'd3);
    compared++; if (busy !== 1'b1 || filt_sel !== 4'd0) begin failed++; $display("FAIL apply_pend got busy=%0b sel=%0d want 1/0", busy, filt_sel); end
    step(1, 639, 479, 0, 4'd0);
    compared++; if (filt_sel !== 4'd3) begin failed++; $display("FAIL apply_sel got %0d want 3", filt_sel); end
    compared++; if (applied !== 1'b1 || bypass !== 1'b1) begin failed++; $display("FAIL apply_pulse got applied=%0b byp=%0b want 1/1", applied, bypass); end
    step(1, 0, 0, 0, 4'd0);
    compared++; if (applied !== 1'b0 || bypass !== 1'b1) begin failed++; $display("FAIL apply_once got applied=%0b byp=%0b want 0/1", applied, bypass); end
    step(1, 639, 0, 0, 4'd0);
    compared++; if (bypass !== 1'b1 || busy !== 1'b1) begin failed++; $display("FAIL flush_line0 got byp=%0b busy=%0b want 1/1", bypass, busy); end
    step(1, 639, 1, 0, 4'd0);
    compared++; if (bypass !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL flush_done got byp=%0b busy=%0b want 0/0", bypass, busy); end
  endtask

  task automatic test_overwrite;
    int n = 0;
    step(1, 10, 5, 1, 4'd2);
    step(1, 20, 9, 1, 4'd5);
    step(1, 639, 479, 0, 4'd0); n += int'(applied);
    step(1, 0, 0, 0, 4'd0);     n += int'(applied);
    compared++; if (filt_sel !== 4'd5) begin failed++; $display("FAIL overwrite_sel got %0d want 5", filt_sel); end
    compared++; if (n !== 1) begin failed++; $display("FAIL overwrite_pulses got %0d want 1", n); end
    step(1, 639, 0, 0, 4'd0);
    step(1, 639, 1, 0, 4'd0);
    compared++; if (busy !== 1'b0) begin failed++; $display("FAIL overwrite_idle got busy=%0b want 0", busy); end
  endtask

  task automatic test_illegal;
    step(1, 3, 3, 1, 4'd12);
    compared++; if (req_err !== 1'b1) begin failed++; $display("FAIL illegal_err got %0b want 1", req_err); end
    compared++; if (filt_sel !== 4'd5 || busy !== 1'b0) begin failed++; $display("FAIL illegal_state got sel=%0d busy=%0b want 5/0", filt_sel, busy); end
    step(1, 4, 3, 0, 4'd0);
    compared++; if (req_err !== 1'b0) begin failed++; $display("FAIL illegal_once got %0b want 0", req_err); end
    step(1, 5, 3, 1, 4'd5);
    compared++; if (busy !== 1'b0 || req_err !== 1'b0) begin failed++; $display("FAIL same_sel_drop got busy=%0b err=%0b want 0/0", busy, req_err); end
    step(1, 639, 479, 0, 4'd0);
    compared++; if (filt_sel !== 4'd5 || applied !== 1'b0 || bypass !== 1'b0)
      begin failed++; $display("FAIL illegal_no_pend got sel=%0d app=%0b byp=%0b want 5/0/0", filt_sel, applied, bypass); end
  endtask

  task automatic test_frame_end_req;
    step(1, 639, 479, 1, 4'd7);
    compared++; if (filt_sel !== 4'd7) begin failed++; $display("FAIL fe_req_sel got %0d want 7", filt_sel); end
    compared++; if (bypass !== 1'b1 || applied !== 1'b1) begin failed++; $display("FAIL fe_req_byp got byp=%0b app=%0b want 1/1", bypass, applied); end
  endtask

  task automatic test_flush_req;
    step(1, 0, 0, 1, 4'd4);
    compared++; if (filt_sel !== 4'd7) begin failed++; $display("FAIL flush_hold0 got %0d want 7", filt_sel); end
    step(1, 639, 0, 0, 4'd0);
    compared++; if (filt_sel !== 4'd7 || bypass !== 1'b1) begin failed++; $display("FAIL flush_hold1 got sel=%0d byp=%0b want 7/1", filt_sel, bypass); end
    step(1, 639, 1, 0, 4'd0);
    compared++; if (bypass !== 1'b0 || busy !== 1'b1 || filt_sel !== 4'd7)
      begin failed++; $display("FAIL flush_to_pend got byp=%0b busy=%0b sel=%0d want 0/1/7", bypass, busy, filt_sel); end
    step(1, 639, 479, 0, 4'd0);
    compared++; if (filt_sel !== 4'd4 || applied !== 1'b1) begin failed++; $display("FAIL flush_req_apply got sel=%0d app=%0b want 4/1", filt_sel, applied); end
  endtask

  task automatic test_reset_mid_flush;
    compared++; if (bypass !== 1'b1) begin failed++; $display("FAIL mid_flush_setup got byp=%0b want 1", bypass); end
    step(1, 5, 0, 1, 4'd8);
    @(negedge clk); rst = 1'b0; #1;
    compared++; if (filt_sel !== 4'd0 || bypass !== 1'b0 || busy !== 1'b0)
      begin failed++; $display("FAIL async_reset got sel=%0d byp=%0b busy=%0b want 0/0/0", filt_sel, bypass, busy); end
    @(negedge clk); rst = 1'b1;
    step(1, 639, 479, 0, 4'd0);
    compared++; if (filt_sel !== 4'd0 || applied !== 1'b0 || busy !== 1'b0)
      begin failed++; $display("FAIL pend_lost got sel=%0d app=%0b busy=%0b want 0/0/0", filt_sel, applied, busy); end
  endtask

  initial begin
    test_reset();
    test_apply();
    test_overwrite();
    test_illegal();
    test_frame_end_req();
    test_flush_req();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
